// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between port A (core LSU)
// and port B (debug/DMA loader); one transaction per three cycles, one-cycle response pulse.
module data_memory_arbiter #(
    parameter int MEMORY_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   a_req_valid,
    output logic                   a_req_ready,
    input  logic                   a_req_write,
    input  logic [MEMORY_BITS-1:0] a_req_address,
    input  logic [MEMORY_BITS-1:0] a_req_data,
    output logic                   a_resp_valid,
    output logic [MEMORY_BITS-1:0] a_resp_data,

    input  logic                   b_req_valid,
    output logic                   b_req_ready,
    input  logic                   b_req_write,
    input  logic [MEMORY_BITS-1:0] b_req_address,
    input  logic [MEMORY_BITS-1:0] b_req_data,
    output logic                   b_resp_valid,
    output logic [MEMORY_BITS-1:0] b_resp_data,

    output logic                   mem_write_enable,
    output logic [MEMORY_BITS-1:0] mem_address,
    output logic [MEMORY_BITS-1:0] mem_data_in,
    input  logic [MEMORY_BITS-1:0] mem_data_out,

    output logic                   busy
);

    localparam int MB = MEMORY_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_reg;
    logic            last_grant_reg;    // 0 = port A, 1 = port B
    logic            owner_reg;
    logic            write_reg;
    logic            mem_write_enable_reg;
    logic [MB-1:0]   address_reg;
    logic [MB-1:0]   data_reg;

    // Both ports gathered into arrays so the per-port logic can be generated once.
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [MB-1:0]   req_address [2];
    logic [MB-1:0]   req_data    [2];
    logic [1:0]      grant;
    logic            accept;
    logic            winner;

    assign req_valid      = {b_req_valid, a_req_valid};
    assign req_write      = {b_req_write, a_req_write};
    assign req_address[0] = a_req_address;
    assign req_address[1] = b_req_address;
    assign req_data[0]    = a_req_data;
    assign req_data[1]    = b_req_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);

            logic          resp_valid_reg;
            logic [MB-1:0] resp_data_reg;

            // A contested grant goes to the port that was not served last.
            assign grant[gi] = (state_reg == IDLE) && !rst && req_valid[gi] &&
                               (!req_valid[1-gi] || (last_grant_reg != PORT_ID));

            always_ff @(posedge clk) begin
                if (rst) begin
                    resp_valid_reg <= 1'b0;
                    resp_data_reg  <= '0;
                end else begin
                    resp_valid_reg <= (state_reg == ACCESS) && (owner_reg == PORT_ID);
                    if ((state_reg == ACCESS) && (owner_reg == PORT_ID)) begin
                        resp_data_reg <= write_reg ? '0 : mem_data_out;
                    end
                end
            end
        end
    endgenerate

    assign accept = |grant;
    assign winner = grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= IDLE;
            last_grant_reg       <= 1'b1;
            owner_reg            <= 1'b0;
            write_reg            <= 1'b0;
            mem_write_enable_reg <= 1'b0;
            address_reg          <= '0;
            data_reg             <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg            <= ACCESS;
                        owner_reg            <= winner;
                        last_grant_reg       <= winner;
                        write_reg            <= req_write[winner];
                        mem_write_enable_reg <= req_write[winner];
                        address_reg          <= req_address[winner];
                        data_reg             <= req_data[winner];
                    end
                end
                ACCESS: begin
                    state_reg            <= RESP;
                    mem_write_enable_reg <= 1'b0;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg            <= IDLE;
                    mem_write_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    // Address and data registers hold after the access so the memory's idle read stays put.
    assign mem_write_enable = mem_write_enable_reg;
    assign mem_address      = address_reg;
    assign mem_data_in      = data_reg;

    assign a_req_ready  = grant[0];
    assign b_req_ready  = grant[1];
    assign a_resp_valid = g_port[0].resp_valid_reg;
    assign a_resp_data  = g_port[0].resp_data_reg;
    assign b_resp_valid = g_port[1].resp_valid_reg;
    assign b_resp_data  = g_port[1].resp_data_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: table of single transactions, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_data_memory_arbiter;

    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_write;
    logic [MB-1:0] a_req_address, a_req_data;
    logic          a_resp_valid;
    logic [MB-1:0] a_resp_data;
    logic          b_req_valid, b_req_ready, b_req_write;
    logic [MB-1:0] b_req_address, b_req_data;
    logic          b_resp_valid;
    logic [MB-1:0] b_resp_data;
    logic          mem_write_enable;
    logic [MB-1:0] mem_address, mem_data_in, mem_data_out;
    logic          busy;

    always #5 clk = ~clk;

    data_memory_arbiter #(.MEMORY_BITS(MB)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_address(a_req_address), .a_req_data(a_req_data),
        .a_resp_valid(a_resp_valid), .a_resp_data(a_resp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_address(b_req_address), .b_req_data(b_req_data),
        .b_resp_valid(b_resp_valid), .b_resp_data(b_resp_data),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .busy(busy)
    );

    // Behavioural data_memory: writes on posedge, read data updates at negedge.
    logic [MB-1:0] mem_arr [256];
    logic          mem_clear = 1'b1;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
        end else if (mem_write_enable) begin
            mem_arr[mem_address] <= mem_data_in;
        end
    end

    always @(negedge clk) mem_data_out <= mem_arr[mem_address];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input bit v, input bit w,
                           input logic [MB-1:0] addr, input logic [MB-1:0] data);
        if (p) begin
            b_req_valid = v; b_req_write = w; b_req_address = addr; b_req_data = data;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_address = addr; a_req_data = data;
        end
    endtask

    function automatic logic ready_of(input bit p);
        return p ? b_req_ready : a_req_ready;
    endfunction

    function automatic logic resp_valid_of(input bit p);
        return p ? b_resp_valid : a_resp_valid;
    endfunction

    function automatic logic [MB-1:0] resp_data_of(input bit p);
        return p ? b_resp_data : a_resp_data;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        #1;
        check("ready_during_reset", 32'(a_req_ready), 32'd0);
        step();
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_we", 32'(mem_write_enable), 32'd0);
        check("reset_addr", 32'(mem_address), 32'd0);
        check("reset_din", 32'(mem_data_in), 32'd0);
        check("reset_resp_valid", 32'({a_resp_valid, b_resp_valid}), 32'd0);
        check("reset_resp_data", 32'({a_resp_data, b_resp_data}), 32'd0);
    endtask

    // One isolated transaction, checked cycle by cycle from request to response.
    task automatic run_txn(input bit p, input bit w, input logic [MB-1:0] addr,
                           input logic [MB-1:0] data, input logic [MB-1:0] exp_rd);
        set_req(p, 1'b1, w, addr, data);
        #1;
        check("txn_ready", 32'(ready_of(p)), 32'd1);
        check("txn_other_ready", 32'(ready_of(!p)), 32'd0);
        step();
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
        check("access_busy", 32'(busy), 32'd1);
        check("access_we", 32'(mem_write_enable), 32'(w));
        check("access_addr", 32'(mem_address), 32'(addr));
        if (w) check("access_din", 32'(mem_data_in), 32'(data));
        step();
        check("resp_valid", 32'(resp_valid_of(p)), 32'd1);
        check("resp_other_valid", 32'(resp_valid_of(!p)), 32'd0);
        check("resp_data", 32'(resp_data_of(p)), 32'(exp_rd));
        check("resp_we", 32'(mem_write_enable), 32'd0);
        step();
        check("post_resp_valid", 32'(resp_valid_of(p)), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_resp_hold", 32'(resp_data_of(p)), 32'(exp_rd));
        $display("txn port=%s %s addr=0x%02h data=0x%02h resp=0x%02h",
                 p ? "B" : "A", w ? "WR" : "RD", addr, data, resp_data_of(p));
    endtask

    typedef struct {
        bit            port;
        bit            write;
        logic [MB-1:0] addr;
        logic [MB-1:0] data;
        logic [MB-1:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    // Reference model state for the randomized phase.
    logic [MB-1:0] ref_mem [256];

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 8'h3F, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 8'h11, 8'h33, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 8'h11, 8'h00, 8'h33};
        vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h7E, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h7E};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 8'hC3, 8'h00};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hC3};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        mem_clear = 1'b0;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].port, vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);
        end

        // Continuous contention straight after reset: A, B, A, B, three cycles apart.
        begin
            bit grants [4];
            int cycs [4];
            int n = 0;
            do_reset();
            set_req(1'b0, 1'b1, 1'b1, 8'h40, 8'h11);
            set_req(1'b1, 1'b1, 1'b0, 8'h41, 8'h00);
            for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
                #1;
                check("both_ready_exclusive", 32'(a_req_ready & b_req_ready), 32'd0);
                if (a_req_ready || b_req_ready) begin
                    grants[n] = b_req_ready;
                    cycs[n] = cyc;
                    $display("txn contention grant=%s cycle=%0d", b_req_ready ? "B" : "A", cyc);
                    n++;
                end
                step();
            end
            check("contention_count", 32'(n), 32'd4);
            for (int i = 0; i < n; i++) begin
                check("contention_grant", 32'(grants[i]), 32'(i % 2));
                if (i > 0) check("contention_spacing", 32'(cycs[i] - cycs[i-1]), 32'd3);
            end
            set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            step(); step(); step();
        end

        // Reset at E1 of a write: write commits, response is dropped.
        set_req(1'b0, 1'b1, 1'b1, 8'h20, 8'h5A);
        #1;
        check("rst_e1_ready", 32'(a_req_ready), 32'd1);
        step();
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_e1_no_resp", 32'(a_resp_valid), 32'd0);
        check("rst_e1_busy", 32'(busy), 32'd0);
        step();
        check("rst_e1_no_resp_later", 32'(a_resp_valid), 32'd0);
        $display("txn port=A WR addr=0x20 aborted by reset");
        run_txn(1'b0, 1'b0, 8'h20, 8'h00, 8'h5A);

        // A drops valid while B (which won on fairness) is in ACCESS.
        run_txn(1'b0, 1'b1, 8'h50, 8'h0F, 8'h00);
        set_req(1'b0, 1'b1, 1'b0, 8'h50, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, 8'h51, 8'h99);
        #1;
        check("drop_b_ready", 32'(b_req_ready), 32'd1);
        check("drop_a_ready", 32'(a_req_ready), 32'd0);
        step();
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("drop_b_resp", 32'(b_resp_valid), 32'd1);
        check("drop_a_resp", 32'(a_resp_valid), 32'd0);
        step();
        check("drop_idle_ready", 32'({a_req_ready, b_req_ready}), 32'd0);
        check("drop_idle_we", 32'(mem_write_enable), 32'd0);
        check("drop_idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("drop_no_a_txn", 32'({a_resp_valid, busy}), 32'd0);
        end
        $display("txn port=B WR addr=0x51 data=0x99 with A dropped");

        // Randomized traffic against a transaction-level model.
        begin
            int            m_cnt = 0;          // cycles until idle after current edge
            bit            m_last = 1'b1;
            bit            m_owner = 1'b0;
            bit            m_wr = 1'b0;
            logic [MB-1:0] m_addr = '0;
            logic [MB-1:0] m_din = '0;
            logic [MB-1:0] m_resp = '0;
            logic [MB-1:0] exp_rd [2];
            bit            acc_prev = 1'b0;
            bit            acc_port = 1'b0;
            bit            pend [2];
            bit            pw [2];
            logic [MB-1:0] pa [2];
            logic [MB-1:0] pd [2];
            bit            er [2];

            do_reset();
            for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
            exp_rd[0] = '0; exp_rd[1] = '0;
            pend[0] = 0; pend[1] = 0;
            pw[0] = 0; pw[1] = 0; pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;

            for (int cyc = 0; cyc < 600; cyc++) begin
                if (m_cnt > 0) m_cnt--;
                if (acc_prev) begin
                    m_cnt   = 2;
                    m_owner = acc_port;
                    m_resp  = m_wr ? '0 : ref_mem[m_addr];
                    if (m_wr) ref_mem[m_addr] = m_din;
                end
                if (m_cnt == 1) exp_rd[m_owner] = m_resp;

                check("rnd_busy", 32'(busy), 32'(m_cnt != 0));
                check("rnd_we", 32'(mem_write_enable), 32'(m_cnt == 2 && m_wr));
                if (m_cnt == 2) check("rnd_addr", 32'(mem_address), 32'(m_addr));
                check("rnd_a_resp_valid", 32'(a_resp_valid), 32'(m_cnt == 1 && !m_owner));
                check("rnd_b_resp_valid", 32'(b_resp_valid), 32'(m_cnt == 1 && m_owner));
                check("rnd_a_resp_data", 32'(a_resp_data), 32'(exp_rd[0]));
                check("rnd_b_resp_data", 32'(b_resp_data), 32'(exp_rd[1]));

                for (int p = 0; p < 2; p++) begin
                    if (!pend[p]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            pend[p] = 1'b1;
                            pw[p]   = 1'($urandom_range(0, 1));
                            pa[p]   = 8'($urandom_range(0, 15));
                            pd[p]   = 8'($urandom);
                        end
                    end else if ($urandom_range(0, 9) == 0) begin
                        pend[p] = 1'b0;
                    end
                    set_req(p[0], pend[p], pw[p], pa[p], pd[p]);
                end
                #1;

                er[0] = (m_cnt == 0) && pend[0] && (!pend[1] || m_last);
                er[1] = (m_cnt == 0) && pend[1] && (!pend[0] || !m_last);
                check("rnd_a_ready", 32'(a_req_ready), 32'(er[0]));
                check("rnd_b_ready", 32'(b_req_ready), 32'(er[1]));

                acc_prev = er[0] || er[1];
                if (acc_prev) begin
                    acc_port = er[1];
                    m_last   = acc_port;
                    m_wr     = pw[acc_port];
                    m_addr   = pa[acc_port];
                    m_din    = pd[acc_port];
                    pend[acc_port] = 1'b0;
                    $display("txn rnd port=%s %s addr=0x%02h data=0x%02h",
                             acc_port ? "B" : "A", m_wr ? "WR" : "RD", m_addr, m_din);
                end
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
